// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage enabled register pipeline with per-stage valid bits,
// synchronous flush, and a registered count of occupied stages.
module dff_pipe #(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Occupancy after an enabled shift: one entry may enter, the oldest may leave.
  always_comb begin
    count_d = count_q + CW'(in_valid) - CW'(v[DEPTH-1]);
  end

  // Data stages: reset loads RESET_VAL, flush leaves data untouched, en shifts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= RESET_VAL;
      end
    end else if (!flush && en) begin
      d[0] <= in;
      for (int k = 1; k < DEPTH; k++) begin
        d[k] <= d[k-1];
      end
    end
  end

  // Valid bits and occupancy count: reset and flush both empty the pipe.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      v       <= '0;
      count_q <= '0;
    end else if (en) begin
      v[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
      end
      count_q <= count_d;
    end
  end

  assign out       = d[DEPTH-1];
  assign out_valid = v[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: drives a WIDTH=8/DEPTH=4 pipe and a WIDTH=16/DEPTH=1 pipe with
// the same stimulus and checks both against a queue-based reference model.
module tb_dff_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in16 = '0;

  logic [7:0]  a_out;
  logic        a_out_valid;
  logic [2:0]  a_count;
  logic [15:0] b_out;
  logic        b_out_valid;
  logic        b_count;

  int compared = 0;
  int mismatched = 0;

  // Reference: each pipe is a queue of (valid, data) entries, newest at front.
  logic [7:0]  qa_d [$];
  bit          qa_v [$];
  logic [15:0] qb_d [$];
  bit          qb_v [$];

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut_a (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in(in16[7:0]),
    .out(a_out), .out_valid(a_out_valid), .count(a_count)
  );

  dff_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'hFFFF)) dut_b (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in(in16),
    .out(b_out), .out_valid(b_out_valid), .count(b_count)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int occupancy(input bit vq [$]);
    int n = 0;
    foreach (vq[i]) n += int'(vq[i]);
    return n;
  endfunction

  // Apply the edge rules to both models using the inputs sampled at posedge.
  task automatic model_edge();
    if (!reset) begin
      qa_d.delete(); qa_v.delete(); qb_d.delete(); qb_v.delete();
      for (int i = 0; i < 4; i++) begin
        qa_d.push_back(8'h00); qa_v.push_back(1'b0);
      end
      qb_d.push_back(16'hFFFF); qb_v.push_back(1'b0);
    end else if (flush) begin
      foreach (qa_v[i]) qa_v[i] = 1'b0;
      foreach (qb_v[i]) qb_v[i] = 1'b0;
    end else if (en) begin
      qa_d.push_front(in16[7:0]); qa_v.push_front(in_valid);
      void'(qa_d.pop_back()); void'(qa_v.pop_back());
      qb_d.push_front(in16); qb_v.push_front(in_valid);
      void'(qb_d.pop_back()); void'(qb_v.pop_back());
    end
  endtask

  task automatic step(input bit r, input bit e, input bit f, input bit iv,
                      input logic [15:0] din);
    @(negedge clk);
    reset = r; en = e; flush = f; in_valid = iv; in16 = din;
    @(posedge clk);
    model_edge();
    #1;
    chk("a_out", 16'(a_out), 16'(qa_d[3]));
    chk("a_out_valid", 16'(a_out_valid), 16'(qa_v[3]));
    chk("a_count", 16'(a_count), 16'(occupancy(qa_v)));
    chk("b_out", b_out, qb_d[0]);
    chk("b_out_valid", 16'(b_out_valid), 16'(qb_v[0]));
    chk("b_count", 16'(b_count), 16'(occupancy(qb_v)));
  endtask

  initial begin
    logic [7:0] seq [4];

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
    chk("rst_a_out", 16'(a_out), 16'h0000);
    chk("rst_b_out", b_out, 16'hFFFF);
    chk("rst_a_count", 16'(a_count), 16'd0);

    // Four valid words fill the pipe; first emerges on the 4th edge
    seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hD4;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, {8'h70 + 8'(i), seq[i]});
    chk("fill_out", 16'(a_out), 16'h00A1);
    chk("fill_valid", 16'(a_out_valid), 16'd1);
    chk("fill_count", 16'(a_count), 16'd4);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h00E0 + 16'(i));
      chk("drain_out", 16'(a_out), 16'(seq[i]));
      chk("full_count", 16'(a_count), 16'd4);
    end

    // Flush a full pipe while offering a valid word
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h00EE);
    chk("flush_valid", 16'(a_out_valid), 16'd0);
    chk("flush_count", 16'(a_count), 16'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Stream two words, hold three cycles, then resume
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0011);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0022);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'($urandom), 16'($urandom));
      chk("hold_count", 16'(a_count), 16'd2);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("hold_out", 16'(a_out), 16'h0011);
    chk("hold_valid", 16'(a_out_valid), 16'd1);

    // Alternating bubbles after emptying the pipe
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'(~i[0]), 16'(i + 1));
    chk("bubble_valid", 16'(a_out_valid), 16'd1);
    chk("bubble_out", 16'(a_out), 16'h0001);
    chk("bubble_count", 16'(a_count), 16'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("bubble_valid2", 16'(a_out_valid), 16'd0);

    // Mid-stream reset overrides flush and en
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0030 + 16'(i));
    chk("pre_rst_count", 16'(a_count), 16'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0099);
    chk("mid_rst_out", 16'(a_out), 16'h0000);
    chk("mid_rst_count", 16'(a_count), 16'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h005A);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("post_rst_out", 16'(a_out), 16'h005A);
    chk("post_rst_valid", 16'(a_out_valid), 16'd1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) >= 3), ($urandom_range(99) < 70),
           ($urandom_range(99) < 5), 1'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range >= 1.
REQ-002 Parameter DEPTH, default 4: number of register stages, legal range >= 1.
REQ-003 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into every data stage on reset.
REQ-004 clk  input  1: single clock; all state updates on posedge clk.
REQ-005 reset  input  1: synchronous, active-low reset; sampled on posedge clk; 1'b0 = reset.
REQ-006 en  input  1: advance enable; 1 = pipeline shifts one stage, 0 = hold.
REQ-007 flush  input  1: 1 = invalidate all stages on this edge.
REQ-008 in_valid  input  1: qualifies in.
REQ-009 in  input  WIDTH: data entering stage 0.
REQ-010 out  output  WIDTH: data in stage DEPTH-1, driven directly from a register.
REQ-011 out_valid  output  1: valid bit of stage DEPTH-1, driven directly from a register.
REQ-012 count  output  $clog2(DEPTH+1): number of stages currently holding valid data, registered.

Function
REQ-013 Block SHALL hold DEPTH data registers d[0..DEPTH-1] and DEPTH valid bits v[0..DEPTH-1].
REQ-014 Edge priority SHALL be: reset, then flush, then en, then hold.
REQ-015 en=1, flush=0: d[0]<=in, v[0]<=in_valid, d[k]<=d[k-1], v[k]<=v[k-1] for k=1..DEPTH-1.
REQ-016 en=0, flush=0: all d and v SHALL hold; in and in_valid are ignored.
REQ-017 Latency SHALL be exactly DEPTH enabled edges from sampling in to its appearance on out; cycles with en=0 add no shifting.
REQ-018 DEPTH=1 SHALL behave as a single enabled register with valid: out/out_valid follow in/in_valid one enabled edge later.
REQ-019 flush=1 (reset=1): all v SHALL clear to 0 and count to 0 regardless of en; d registers hold their values; in is dropped even if in_valid=1 and en=1.
REQ-020 out SHALL carry d[DEPTH-1] whether or not out_valid=1; consumers qualify with out_valid.
REQ-021 count SHALL equal the number of v bits that are 1 after each edge: en=1 adds in_valid and subtracts the old v[DEPTH-1]; en=0 leaves it unchanged.
REQ-022 count SHALL never exceed DEPTH or wrap; in_valid=1 into a full pipe with en=1 leaves count=DEPTH, the oldest entry leaving on out.
REQ-023 Invalid bubbles (in_valid=0) SHALL occupy stages and shift like valid data.
REQ-024 No combinational path SHALL exist from any input to any output.

Reset
REQ-025 reset=0 at posedge clk: every d SHALL load RESET_VAL, every v and out_valid SHALL be 0, count SHALL be 0, overriding flush and en.
REQ-026 reset asserted mid-stream SHALL discard all in-flight data; the first enabled edge after release samples in into stage 0 as from an empty pipe.
REQ-027 Outputs SHALL be undefined before the first reset edge; no asynchronous behaviour is permitted.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=8'h00)
REQ-028 Reset then en=1, in_valid=1, in=8'hA1,8'hB2,8'hC3,8'hD4 on 4 consecutive edges -> out=8'hA1 with out_valid=1 on the 4th edge, then B2,C3,D4; count reaches 4.
REQ-029 Stream 8'h11,8'h22 with en=1, then hold en=0 for 3 cycles, then en=1 -> outputs and count frozen during the hold; 8'h11 appears on out after exactly 4 enabled edges.
REQ-030 Pipe full (count=4), assert flush=1 with en=1, in_valid=1, in=8'hEE -> next edge out_valid=0, count=0; 8'hEE never appears as valid.
REQ-031 Alternate in_valid=1,0,1,0 with in=8'h01..8'h04 -> out_valid pattern 1,0,1,0 starting at the 4th edge; count settles at 2.
REQ-032 Pipe holding 3 valid entries, drive reset=0 for one edge with en=1, flush=1 -> out=8'h00, out_valid=0, count=0; a subsequent 8'h5A emerges after 4 enabled edges.
REQ-033 Re-run REQ-028 with DEPTH=1, WIDTH=16, RESET_VAL=16'hFFFF -> out=16'hFFFF after reset, data emerges one edge after sampling, count toggles 0/1.
